// File: rtl/apb_io_pkg.sv
// Shared types and helpers for the APB I/O decoder-bridge.
package apb_io_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int unsigned ERR_CNT_W  = 8;
  localparam int unsigned WDOG_CNT_W = 16;

  // True when a decoded select field addresses an existing slave.
  function automatic logic idx_mapped(input logic [31:0] idx, input int unsigned num);
    return idx < num;
  endfunction

endpackage

// File: rtl/apb_io_watchdog.sv
// Clearable ACCESS-phase cycle counter; o_tc_c flags the cycle that reaches TERM.
module apb_io_watchdog
  import apb_io_pkg::*;
#(
  parameter int unsigned TERM = 255
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc_c
);

  localparam logic [WDOG_CNT_W-1:0] TC_VAL = WDOG_CNT_W'(TERM - 1);

  logic [WDOG_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc_c = i_en && (r_cnt == TC_VAL);

endmodule

// File: rtl/apb_io_decoder.sv
// APB I/O decoder-bridge: registered setup/access re-timing, error response and logging.
// Optional ACCESS watchdog enabled by defining APB_DECODER_TIMEOUT_EN.
module apb_io_decoder
  import apb_io_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SEL_LSB    = 8,
  parameter int unsigned SEL_W      = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic [ADDR_W-1:0]            m_paddr,
  input  logic [DATA_W-1:0]            m_pwdata,
  input  logic                         m_pwrite,
  input  logic                         m_psel,
  input  logic                         m_penable,
  output logic [DATA_W-1:0]            m_prdata,
  output logic                         m_pready,
  output logic                         m_pslverr,
  output logic [ADDR_W-1:0]            s_paddr,
  output logic [DATA_W-1:0]            s_pwdata,
  output logic                         s_pwrite,
  output logic                         s_penable,
  output logic [NUM_SLAVES-1:0]        s_psel,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_prdata,
  input  logic [NUM_SLAVES-1:0]        s_pready,
  output logic                         err_pulse,
  output logic [ERR_CNT_W-1:0]         err_count,
  output logic [ADDR_W-1:0]            err_addr
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  state_t                  r_state, w_state_nxt;
  logic [IDX_W-1:0]        r_idx, w_idx_nxt;
  logic [ADDR_W-1:0]       r_addr, w_addr_nxt;
  logic [DATA_W-1:0]       r_wdata, w_wdata_nxt;
  logic                    r_write, w_write_nxt;
  logic [NUM_SLAVES-1:0]   r_psel, w_psel_nxt;
  logic                    r_penable, w_penable_nxt;
  logic [DATA_W-1:0]       r_prdata, w_prdata_nxt;
  logic                    r_pready, w_pready_nxt;
  logic                    r_pslverr, w_pslverr_nxt;
  logic                    r_err_pulse, w_err_pulse_nxt;
  logic [ERR_CNT_W-1:0]    r_err_count, w_err_count_nxt;
  logic [ADDR_W-1:0]       r_err_addr, w_err_addr_nxt;

  logic [SEL_W-1:0]        w_sel_field;
  logic [IDX_W-1:0]        w_sel_idx;
  logic                    w_mapped;
  logic                    w_ready;
  logic [DATA_W-1:0]       w_rdata;
  logic                    w_err_c;
  logic                    w_timeout_c;

  assign w_sel_field = m_paddr[SEL_LSB +: SEL_W];
  assign w_sel_idx   = IDX_W'(w_sel_field);
  assign w_mapped    = idx_mapped(32'(w_sel_field), NUM_SLAVES);

  // Ready / read-data mux for the currently addressed slave.
  always_comb begin
    w_ready = 1'b0;
    w_rdata = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_ready = s_pready[i];
        w_rdata = s_prdata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef APB_DECODER_TIMEOUT_EN
  logic w_wd_clr;
  logic w_wd_en;

  assign w_wd_clr = (r_state == SETUP);
  assign w_wd_en  = (r_state == ACCESS) && !w_ready;

  apb_io_watchdog #(
    .TERM (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_clr  (w_wd_clr),
    .i_en   (w_wd_en),
    .o_tc_c (w_timeout_c)
  );
`else
  // No watchdog: ACCESS waits for the slave forever (legal TIMEOUT is never 0).
  assign w_timeout_c = (TIMEOUT == 0);
`endif

  // Next state and next registered outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_write_nxt     = r_write;
    w_psel_nxt      = '0;
    w_penable_nxt   = 1'b0;
    w_prdata_nxt    = '0;
    w_pready_nxt    = 1'b0;
    w_pslverr_nxt   = 1'b0;
    w_err_pulse_nxt = 1'b0;
    w_err_count_nxt = r_err_count;
    w_err_addr_nxt  = r_err_addr;
    w_err_c         = 1'b0;

    case (r_state)
      IDLE: begin
        if (m_psel && !m_penable) begin
          w_addr_nxt  = m_paddr;
          w_wdata_nxt = m_pwdata;
          w_write_nxt = m_pwrite;
          w_idx_nxt   = w_sel_idx;
          if (w_mapped) begin
            w_state_nxt = SETUP;
            w_psel_nxt  = NUM_SLAVES'(1) << w_sel_idx;
          end else begin
            w_state_nxt  = RESP;
            w_pready_nxt = 1'b1;
            w_err_c      = 1'b1;
          end
        end
      end
      SETUP: begin
        w_state_nxt   = ACCESS;
        w_psel_nxt    = NUM_SLAVES'(1) << r_idx;
        w_penable_nxt = 1'b1;
      end
      ACCESS: begin
        if (w_ready) begin
          w_state_nxt  = RESP;
          w_pready_nxt = 1'b1;
          w_prdata_nxt = r_write ? '0 : w_rdata;
        end else if (w_timeout_c) begin
          w_state_nxt  = RESP;
          w_pready_nxt = 1'b1;
          w_err_c      = 1'b1;
        end else begin
          w_psel_nxt    = NUM_SLAVES'(1) << r_idx;
          w_penable_nxt = 1'b1;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Error log is updated on entry to RESP so it is visible with the error response.
    if (w_err_c) begin
      w_pslverr_nxt   = 1'b1;
      w_err_pulse_nxt = 1'b1;
      w_err_addr_nxt  = w_addr_nxt;
      if (r_err_count != '1) begin
        w_err_count_nxt = r_err_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_write     <= 1'b0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_prdata    <= '0;
      r_pready    <= 1'b0;
      r_pslverr   <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
      r_err_addr  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_write     <= w_write_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_prdata    <= w_prdata_nxt;
      r_pready    <= w_pready_nxt;
      r_pslverr   <= w_pslverr_nxt;
      r_err_pulse <= w_err_pulse_nxt;
      r_err_count <= w_err_count_nxt;
      r_err_addr  <= w_err_addr_nxt;
    end
  end

  assign m_prdata  = r_prdata;
  assign m_pready  = r_pready;
  assign m_pslverr = r_pslverr;
  assign s_paddr   = r_addr;
  assign s_pwdata  = r_wdata;
  assign s_pwrite  = r_write;
  assign s_penable = r_penable;
  assign s_psel    = r_psel;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_apb_io_decoder.sv
// Directed table-driven bench for apb_io_decoder with a small wait-state slave model.
module tb_apb_io_decoder;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [15:0] m_paddr;
  logic [7:0]  m_pwdata;
  logic        m_pwrite;
  logic        m_psel;
  logic        m_penable;
  logic [7:0]  m_prdata;
  logic        m_pready;
  logic        m_pslverr;
  logic [15:0] s_paddr;
  logic [7:0]  s_pwdata;
  logic        s_pwrite;
  logic        s_penable;
  logic [3:0]  s_psel;
  logic [31:0] s_prdata;
  logic [3:0]  s_pready;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic [15:0] err_addr;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          wcnt   = 0;
  int          wait_cfg [4];
  logic [7:0]  sdata_cfg [4];

  apb_io_decoder #(
    .NUM_SLAVES (4),
    .ADDR_W     (16),
    .DATA_W     (8),
    .SEL_LSB    (8),
    .SEL_W      (8),
    .TIMEOUT    (8)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .m_paddr   (m_paddr),
    .m_pwdata  (m_pwdata),
    .m_pwrite  (m_pwrite),
    .m_psel    (m_psel),
    .m_penable (m_penable),
    .m_prdata  (m_prdata),
    .m_pready  (m_pready),
    .m_pslverr (m_pslverr),
    .s_paddr   (s_paddr),
    .s_pwdata  (s_pwdata),
    .s_pwrite  (s_pwrite),
    .s_penable (s_penable),
    .s_psel    (s_psel),
    .s_prdata  (s_prdata),
    .s_pready  (s_pready),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  // Slave model: ready once the access phase has lasted wait_cfg[i] cycles.
  always @(posedge clk) wcnt <= s_penable ? wcnt + 1 : 0;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s_pready[i]        = s_psel[i] & s_penable & (wcnt >= wait_cfg[i]);
      s_prdata[i*8 +: 8] = sdata_cfg[i];
    end
  end

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        wr;
    int          wait_n;
    logic [7:0]  sdata;
    int          lat;
    logic [7:0]  rdata;
    logic        err;
    logic [3:0]  psel;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic [15:0] a, input logic [7:0] wd, input logic wr,
                      output int lat, output logic [7:0] rd, output logic err,
                      output logic [3:0] psel1, output logic pen2, output logic [15:0] pa1,
                      output logic [7:0] pw1, output logic pwr1, output logic ep,
                      output logic [7:0] ec, output logic [15:0] ea);
    lat = -1; rd = '0; err = 1'b0; psel1 = '0; pen2 = 1'b0; pa1 = '0; pw1 = '0;
    pwr1 = 1'b0; ep = 1'b0; ec = '0; ea = '0;
    @(negedge clk);
    m_paddr = a; m_pwdata = wd; m_pwrite = wr; m_psel = 1'b1; m_penable = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      m_penable = 1'b1;
      if (k == 1) begin
        psel1 = s_psel; pa1 = s_paddr; pw1 = s_pwdata; pwr1 = s_pwrite;
      end
      if (k == 2) pen2 = s_penable;
      if (m_pready) begin
        lat = k; rd = m_prdata; err = m_pslverr;
        ep = err_pulse; ec = err_count; ea = err_addr;
        break;
      end
    end
    m_psel = 1'b0; m_penable = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [7:0]  rd, ec;
    logic        err, pen2, pwr1, ep, seen;
    logic [3:0]  psel1;
    logic [15:0] pa1, ea;
    logic [7:0]  pw1;
    int          exp_cnt;
    logic [15:0] exp_eaddr;
    int          tgt;

    vecs[0] = '{16'h0103, 8'hA5, 1'b1, 0, 8'h11, 3, 8'h00, 1'b0, 4'b0010};
    vecs[1] = '{16'h0002, 8'h00, 1'b0, 2, 8'h3C, 5, 8'h3C, 1'b0, 4'b0001};
    vecs[2] = '{16'h0700, 8'h00, 1'b0, 0, 8'h00, 1, 8'h00, 1'b1, 4'b0000};
    vecs[3] = '{16'h03FF, 8'h00, 1'b0, 0, 8'h81, 3, 8'h81, 1'b0, 4'b1000};
    vecs[4] = '{16'h0210, 8'h4E, 1'b1, 1, 8'h77, 4, 8'h00, 1'b0, 4'b0100};
    vecs[5] = '{16'h0155, 8'h00, 1'b0, 0, 8'h5A, 3, 8'h5A, 1'b0, 4'b0010};
    vecs[6] = '{16'h0400, 8'h00, 1'b0, 0, 8'h00, 1, 8'h00, 1'b1, 4'b0000};
    vecs[7] = '{16'hFF00, 8'h00, 1'b0, 0, 8'h00, 1, 8'h00, 1'b1, 4'b0000};

    for (int i = 0; i < 4; i++) begin
      wait_cfg[i]  = 0;
      sdata_cfg[i] = 8'h00;
    end
    exp_cnt = 0; exp_eaddr = '0;
    n_rst = 1'b0; m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0; m_psel = 1'b0; m_penable = 1'b0;

    #1;
    chk("reset_m_outs", {m_prdata, m_pready, m_pslverr}, 0);
    chk("reset_s_outs", {s_paddr, s_pwdata, s_pwrite, s_penable, s_psel}, 0);
    chk("reset_err", {err_pulse, err_count, err_addr}, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    for (int v = 0; v < 8; v++) begin
      tgt = int'(vecs[v].addr[15:8]);
      if (tgt < 4) begin
        wait_cfg[tgt]  = vecs[v].wait_n;
        sdata_cfg[tgt] = vecs[v].sdata;
      end
      xfer(vecs[v].addr, vecs[v].wdata, vecs[v].wr, lat, rd, err, psel1, pen2, pa1, pw1, pwr1, ep, ec, ea);
      if (vecs[v].err) begin
        exp_cnt   = exp_cnt + 1;
        exp_eaddr = vecs[v].addr;
      end
      chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      chk($sformatf("v%0d_prdata", v), rd, vecs[v].rdata);
      chk($sformatf("v%0d_pslverr", v), err, vecs[v].err);
      chk($sformatf("v%0d_psel", v), psel1, vecs[v].psel);
      chk($sformatf("v%0d_err_pulse", v), ep, vecs[v].err);
      chk($sformatf("v%0d_err_count", v), ec, exp_cnt);
      chk($sformatf("v%0d_err_addr", v), ea, exp_eaddr);
      if (!vecs[v].err) begin
        chk($sformatf("v%0d_s_paddr", v), pa1, vecs[v].addr);
        chk($sformatf("v%0d_s_pwdata", v), pw1, vecs[v].wdata);
        chk($sformatf("v%0d_s_pwrite", v), pwr1, vecs[v].wr);
        chk($sformatf("v%0d_s_penable", v), pen2, 1);
      end
    end

    // Slave 2 never ready.
    wait_cfg[2] = 100000; sdata_cfg[2] = 8'h77;
`ifdef APB_DECODER_TIMEOUT_EN
    xfer(16'h0200, 8'h00, 1'b0, lat, rd, err, psel1, pen2, pa1, pw1, pwr1, ep, ec, ea);
    exp_cnt = exp_cnt + 1; exp_eaddr = 16'h0200;
    chk("to_latency", lat, 10);
    chk("to_pslverr", err, 1);
    chk("to_prdata", rd, 0);
    chk("to_psel", psel1, 4'b0100);
    chk("to_err_count", ec, exp_cnt);
    chk("to_err_addr", ea, exp_eaddr);
`else
    @(negedge clk);
    m_paddr = 16'h0200; m_pwrite = 1'b0; m_psel = 1'b1; m_penable = 1'b0;
    @(negedge clk);
    m_penable = 1'b1;
    repeat (30) @(negedge clk);
    chk("stall_pready", m_pready, 0);
    chk("stall_penable", s_penable, 1);
    chk("stall_psel", s_psel, 4'b0100);
    wait_cfg[2] = 0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (m_pready) begin
        seen = 1'b1;
        chk("stall_rel_prdata", m_prdata, 8'h77);
        chk("stall_rel_pslverr", m_pslverr, 0);
        break;
      end
    end
    chk("stall_rel_seen", seen, 1);
    m_psel = 1'b0; m_penable = 1'b0;
`endif
    wait_cfg[2] = 0;

    // Saturation of the error counter.
    for (int i = 0; i < 260; i++) begin
      xfer(16'h0900 + 16'(i & 8'hFF), 8'h00, 1'b0, lat, rd, err, psel1, pen2, pa1, pw1, pwr1, ep, ec, ea);
      if (exp_cnt < 255) exp_cnt = exp_cnt + 1;
    end
    chk("sat_count", ec, exp_cnt);
    chk("sat_count_is_255", ec, 255);
    chk("sat_pulse", ep, 1);
    chk("sat_pslverr", err, 1);

    // Reset asserted in the middle of an ACCESS phase.
    wait_cfg[1] = 100000;
    @(negedge clk);
    m_paddr = 16'h0100; m_pwrite = 1'b0; m_psel = 1'b1; m_penable = 1'b0;
    @(negedge clk);
    m_penable = 1'b1;
    @(negedge clk);
    chk("rst_pre_penable", s_penable, 1);
    #2 n_rst = 1'b0;
    #1;
    chk("rst_psel", s_psel, 0);
    chk("rst_penable", s_penable, 0);
    chk("rst_pready", m_pready, 0);
    chk("rst_err_count", err_count, 0);
    m_psel = 1'b0; m_penable = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    wait_cfg[1] = 0; sdata_cfg[1] = 8'h5A;
    xfer(16'h0101, 8'h00, 1'b0, lat, rd, err, psel1, pen2, pa1, pw1, pwr1, ep, ec, ea);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_prdata", rd, 8'h5A);
    chk("post_rst_pslverr", err, 0);
    chk("post_rst_err_count", ec, 0);

    @(negedge clk);
    chk("idle_pready", m_pready, 0);
    chk("idle_psel", s_psel, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_io_decoder.md
# apb_io_decoder

Parametrised APB I/O decoder-bridge between the system's upstream APB master port (`io_apb_if_*`) and up to NUM_SLAVES peripherals (UARTs, GPIOs, timers). Decodes one address field to a slave index, re-times every transfer through a registered setup/access sequence, and muxes read data and ready. Unmapped addresses and stalled slaves complete with an error response rather than hanging the bus. Error events are counted and the last failing address is captured.

## Interface
- NUM_SLAVES, 4: number of downstream slaves, 1..16
- ADDR_W, 16: APB address width
- DATA_W, 8: APB data width
- SEL_LSB, 8: low bit of the slave-select field in paddr
- SEL_W, 8: width of the slave-select field; SEL_LSB+SEL_W <= ADDR_W
- TIMEOUT, 255: maximum downstream access cycles before abort, 2..65535
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- m_paddr  in  ADDR_W  upstream address
- m_pwdata  in  DATA_W  upstream write data
- m_pwrite  in  1  upstream write strobe
- m_psel  in  1  upstream select
- m_penable  in  1  upstream enable
- m_prdata  out  DATA_W  upstream read data
- m_pready  out  1  upstream ready
- m_pslverr  out  1  upstream error
- s_paddr  out  ADDR_W  registered address, broadcast to all slaves
- s_pwdata  out  DATA_W  registered write data, broadcast
- s_pwrite  out  1  registered write, broadcast
- s_penable  out  1  downstream enable, broadcast
- s_psel  out  NUM_SLAVES  one-hot downstream select
- s_prdata  in  NUM_SLAVES*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
- s_pready  in  NUM_SLAVES  per-slave ready
- err_pulse  out  1  one-cycle pulse per errored transfer
- err_count  out  8  saturating error count
- err_addr  out  ADDR_W  address of most recent errored transfer

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: on m_psel=1 & m_penable=0, latch m_paddr, m_pwdata, m_pwrite; compute idx = m_paddr[SEL_LSB +: SEL_W]; mapped = idx < NUM_SLAVES. Mapped -> SETUP; unmapped -> RESP with error flag set.
- SETUP: s_psel[idx]=1, s_penable=0; -> ACCESS.
- ACCESS: s_psel[idx]=1, s_penable=1. If s_pready[idx]=1: capture s_prdata slice (reads only; writes capture 0), error flag 0, -> RESP. Else increment wait counter.
- RESP: m_pready=1, m_prdata=captured data (0 on error), m_pslverr=error flag, for exactly one cycle; -> IDLE.
- Error in RESP: err_pulse=1, err_addr<=latched address, err_count increments, saturating at 255.
- s_psel all-zero and s_penable=0 in IDLE and RESP; never more than one s_psel bit high.
- m_pready, m_pslverr, m_prdata are 0 outside RESP.
- Upstream protocol violations (m_psel dropped before m_pready) are ignored: the in-flight transfer completes downstream, its response cycle is still issued.

## Timing
- All outputs registered; reset value 0 for every output.
- Mapped zero-wait transfer: upstream setup at cycle T, s_psel at T+1, s_penable at T+2, m_pready at T+3. Each slave wait state adds one cycle.
- Unmapped: m_pready with m_pslverr at T+1.
- Back-to-back: next upstream setup accepted in the cycle after RESP (IDLE); minimum 4 cycles per mapped transfer.
- Reset mid-transfer: state forced to IDLE asynchronously, all selects drop immediately; transfer is lost, no error counted.

## Configuration
- APB_DECODER_TIMEOUT_EN defined: ACCESS counts cycles with s_pready[idx]=0; when the count reaches TIMEOUT, drop s_psel/s_penable, error flag 1, -> RESP. Counter clears on entering SETUP.
- Undefined: no counter; ACCESS waits indefinitely for s_pready. Unmapped-address error still active.

## Structure
- Shared package apb_io_pkg: state enum (IDLE, SETUP, ACCESS, RESP), error-count width constant, slave-index decode function.
- Sub-module apb_io_watchdog: loadable/clearable cycle counter with terminal-count output, instantiated only under APB_DECODER_TIMEOUT_EN.

## Test plan
- Write 0xA5 to 0x0103, slave 1 zero-wait -> s_psel=4'b0010 at T+1, s_pwdata=0xA5, s_paddr=0x0103, m_pready at T+3, m_pslverr=0.
- Read 0x0002, slave 0 returns 0x3C after 2 wait states -> m_prdata=0x3C, m_pready at T+5.
- Read 0x0700 (NUM_SLAVES=4) -> m_pready+m_pslverr at T+1, m_prdata=0, err_addr=0x0700, err_count=1, no s_psel asserted.
- TIMEOUT=8, slave 2 never ready -> abort after 8 ACCESS cycles, m_pslverr=1, err_count increments; without macro, bus stays in ACCESS.
- 256 unmapped accesses -> err_count holds at 255.
- Assert n_rst during ACCESS -> s_psel, s_penable, m_pready go 0 immediately; err_count unchanged next transfer succeeds.
